// File: rtl/addseq_pkg.sv
// Shared types and helpers for the wide add sequencer.
// Holds the FSM state encoding, slice width and index-width helper.
package addseq_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wide_add_sequencer_add16_slice.sv
// add16_slice: combinational 16-bit carry-select adder.
// Ports: a, b, cin -> sum, cout. Four 4-bit blocks, each select-muxed.
module add16_slice
   import addseq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   always_comb begin
      logic       c;
      logic [4:0] r0;
      logic [4:0] r1;
      sum = '0;
      c   = cin;
      for (int i = 0; i < 4; i++) begin
         // both carry hypotheses per block; the incoming carry picks one
         r0 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
         r1 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + 5'd1;
         sum[4*i +: 4] = c ? r1[3:0] : r0[3:0];
         c = c ? r1[4] : r0[4];
      end
      cout = c;
   end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder that reuses one 16-bit slice, one slice per clock, LSB first.
// Ports: clk, rst_n, in_* operand handshake, out_* result handshake, busy.
// Define ADDSEQ_SUB_EN to add the in_sub port (A + ~B + 1).
module wide_add_sequencer
   import addseq_pkg::*;
#(
   parameter int NUM_SLICES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SLICE_W*NUM_SLICES-1:0] in_a,
   input  logic [SLICE_W*NUM_SLICES-1:0] in_b,
   input  logic                          in_cin,
`ifdef ADDSEQ_SUB_EN
   input  logic                          in_sub,
`endif
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SLICE_W*NUM_SLICES-1:0] out_sum,
   output logic                          out_cout,
   output logic                          busy
);

   localparam int W  = SLICE_W * NUM_SLICES;
   localparam int IW = idx_w(NUM_SLICES);
   localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

   state_t             st;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       sum_q;
   logic               cy_q;
   logic               cout_q;
   logic [IW-1:0]      idx;
   logic [SLICE_W-1:0] sa;
   logic [SLICE_W-1:0] sb;
   logic [SLICE_W-1:0] ss;
   logic               sc;
   logic               sub;

`ifdef ADDSEQ_SUB_EN
   assign sub = in_sub;
`else
   assign sub = 1'b0;
`endif

   assign sa = a_q[idx*SLICE_W +: SLICE_W];
   assign sb = b_q[idx*SLICE_W +: SLICE_W];

   add16_slice u_slice (
      .a    (sa),
      .b    (sb),
      .cin  (cy_q),
      .sum  (ss),
      .cout (sc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cy_q   <= 1'b0;
         cout_q <= 1'b0;
         idx    <= '0;
      end else begin
         unique case (st)
            IDLE: begin
               if (in_valid) begin
                  a_q    <= in_a;
                  b_q    <= sub ? ~in_b : in_b;
                  cy_q   <= sub | in_cin;
                  sum_q  <= '0;
                  cout_q <= 1'b0;
                  idx    <= '0;
                  st     <= RUN;
               end
            end
            RUN: begin
               sum_q[idx*SLICE_W +: SLICE_W] <= ss;
               cy_q <= sc;
               idx  <= idx + 1'b1;
               if (idx == LAST) begin
                  cout_q <= sc;
                  st     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

   // in_ready gated by rst_n so it reads 0 while reset is held
   assign in_ready  = (st == IDLE) & rst_n;
   assign out_valid = (st == DONE);
   assign busy      = (st == RUN) | (st == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

endmodule
